mem_dump: RTL
=============

Name: mem_dump

Overview:
Reads the sample memory after capture and streams its contents to the UART transmitter as raw bytes. It sits directly downstream of the sample memory and in parallel with the memory-clear stage, and is driven by the same command sequencer through an activate/done pair. A dump starts at a caller-supplied address (the circular-buffer trigger point), wraps around, and covers all 2^SAMPLE_DEPTH words.

Parameters:
SAMPLE_DEPTH, 8, memory address width; a dump covers 2^SAMPLE_DEPTH words.
WIDTH, 8, memory word width; each word is sent as BPW = ceil(WIDTH/8) bytes.

Ports:
clk_50mhz  in  1  system clock; all logic on its rising edge.
reset  in  1  asynchronous, active-low reset (asserted when 0).
activate  in  1  level; 1 requests a dump, 0 returns the block to idle.
done  out  1  high after the last byte is accepted; held until activate drops.
start_addr  in  SAMPLE_DEPTH  first word address; sampled in IDLE when activate is seen.
mem_addr  out  SAMPLE_DEPTH  read address.
mem_re  out  1  read strobe; mem_data is valid the cycle after mem_re=1.
mem_data  in  WIDTH  read data.
tx_data  out  8  byte to the UART.
tx_valid  out  1  byte available.
tx_ready  in  1  UART accepts; a transfer happens when tx_valid && tx_ready on a clock edge.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; done, mem_re, tx_valid = 0; mem_addr, tx_data = 0; all counters cleared.
- IDLE: done=0. When activate=1: latch base=start_addr, word_cnt=0, go to READ.
- READ (1 cycle): mem_addr = (base + word_cnt) mod 2^SAMPLE_DEPTH, mem_re=1, go to WAIT.
- WAIT (1 cycle): mem_re=0. At the end of the cycle, capture mem_data into a WIDTH-bit shift register zero-padded to 8*BPW bits, set byte_idx=0, go to SEND.
- SEND: tx_valid=1, tx_data = shift register[7:0], sent LSB-first.
  - On each transfer: shift right by 8 and increment byte_idx.
  - After byte BPW-1 transfers: increment word_cnt. If word_cnt becomes 2^SAMPLE_DEPTH, go to DONE, otherwise go to READ.
  - tx_valid deasserts in the cycle after the final byte of a word transfers.
- Latency: from activate sampled in IDLE, the first tx_valid=1 appears 3 cycles later. The minimum per-word period is BPW+2 cycles.
- DONE: tx_valid=0, done=1. Stay in DONE while activate=1; go to IDLE when activate=0.
- Ready/valid rules:
  - tx_valid never deasserts and tx_data never changes while tx_valid=1 && tx_ready=0.
  - tx_valid does not depend combinationally on tx_ready.
- Abort: activate=0 in READ or WAIT goes to IDLE on the next edge.
  - In SEND, a pending byte stays valid until accepted, then the block goes to IDLE.
  - done is never asserted for an aborted dump; the next activate restarts from the newly sampled start_addr.
- Counter widths:
  - word_cnt is SAMPLE_DEPTH+1 bits so the terminal count is representable.
  - The address add truncates to SAMPLE_DEPTH bits, so wrap-around is natural.
  - byte_idx is $clog2(BPW)+1 bits.
- Edge cases:
  - start_addr = 2^SAMPLE_DEPTH-1: order is last word, then 0, 1, ...
  - WIDTH not a multiple of 8: the top byte is zero-padded.
  - start_addr changes mid-dump: ignored.
- Reset asserted mid-dump: immediate return to the reset values above, with no partial-byte completion.

Decomposition:
- Shared package osc_pkg holds:
  - dump state enum (IDLE, READ, WAIT, SEND, DONE);
  - function bytes_per_word(width);
  - ready/valid naming constants shared with the UART tx.
- One sub-module is natural: word_serializer. It takes a WIDTH-bit word load plus the ready/valid output side, emits BPW bytes LSB-first, and raises word_done. mem_dump keeps the FSM, the address arithmetic and word_cnt.

Test Plan:
- SAMPLE_DEPTH=4, WIDTH=8, mem[i]=i, start_addr=0, tx_ready=1 -> bytes 0x00..0x0F in order, then done=1; done drops one cycle after activate=0.
- Same memory, start_addr=14 -> bytes 0x0E, 0x0F, 0x00..0x0D; 16 bytes total, then done.
- WIDTH=12, mem[0]=0xABC, mem[1]=0x123 -> first bytes 0xBC, 0x0A, 0x23, 0x01; 2 bytes per word.
- tx_ready random (about 30% high) -> tx_data and tx_valid stable during every stall; byte sequence identical to the tx_ready=1 case.
- activate dropped after 5 transfers with tx_ready=0 -> pending byte held until tx_ready=1, then IDLE, done stays 0; re-activate with start_addr=3 -> first byte 0x03.
- reset=0 asynchronously mid-SEND -> tx_valid, mem_re, done = 0 before the next clock edge; after release, a new activate starts a full dump.

Source files
------------

// File: rtl/osc_pkg.sv
// -----------------------------------------------------------------------------
// osc_pkg
// Shared definitions for the capture read-out path: the dump FSM state
// encoding, the bytes-per-word helper, and the ready/valid polarity
// constants used by both the dump block and the UART transmitter.
// -----------------------------------------------------------------------------
package osc_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } dump_state_t;

    // A beat moves when both sides show their "on" level on a clock edge.
    localparam bit VALID_ON = 1'b1;
    localparam bit READY_ON = 1'b1;

    function automatic int bytes_per_word(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/mem_dump_if.sv
// -----------------------------------------------------------------------------
// mem_dump_if
// Bundles the command (activate/done/start_addr), sample-memory read port and
// UART byte stream of the dump block.
//   master : used by mem_dump (drives done, mem_addr, mem_re, tx_data, tx_valid)
//   slave  : used by the surroundings (sequencer, memory, UART tx)
// -----------------------------------------------------------------------------
interface mem_dump_if #(
    parameter int SAMPLE_DEPTH = 8,
    parameter int WIDTH        = 8
);
    logic                    activate;
    logic                    done;
    logic [SAMPLE_DEPTH-1:0] start_addr;
    logic [SAMPLE_DEPTH-1:0] mem_addr;
    logic                    mem_re;
    logic [WIDTH-1:0]        mem_data;
    logic [7:0]              tx_data;
    logic                    tx_valid;
    logic                    tx_ready;

    modport master (
        input  activate, start_addr, mem_data, tx_ready,
        output done, mem_addr, mem_re, tx_data, tx_valid
    );

    modport slave (
        output activate, start_addr, mem_data, tx_ready,
        input  done, mem_addr, mem_re, tx_data, tx_valid
    );
endinterface

// File: rtl/mem_dump_serializer.sv
// -----------------------------------------------------------------------------
// word_serializer
// Holds one memory word (zero-padded to whole bytes) and presents it LSB-first
// as a ready/valid byte stream.
//   clk, rst_n       : clock, async active-low reset
//   load, word       : capture a new word and start presenting byte 0
//   clear            : drop valid after the current accepted byte (abort)
//   tx_ready         : downstream accept
//   tx_data/tx_valid : byte stream
//   word_done        : last byte of the word is being accepted this cycle
// -----------------------------------------------------------------------------
module word_serializer
    import osc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] word,
    input  logic             tx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    output logic             word_done
);
    localparam int BPW = bytes_per_word(WIDTH);
    localparam int SW  = 8 * BPW;
    localparam int BIW = $clog2(BPW) + 1;
    localparam logic [BIW-1:0] LAST_IDX = BIW'(BPW - 1);

    logic [SW-1:0]  shreg;
    logic [BIW-1:0] byte_idx;
    logic           busy;
    logic           fire;

    // Valid comes straight from a flop, so it never looks at tx_ready.
    assign tx_valid  = busy;
    assign tx_data   = shreg[7:0];
    assign fire      = (busy == VALID_ON) && (tx_ready == READY_ON);
    assign word_done = fire && (byte_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            byte_idx <= '0;
            busy     <= 1'b0;
        end else if (load) begin
            shreg    <= SW'(word);
            byte_idx <= '0;
            busy     <= 1'b1;
        end else if (fire) begin
            shreg    <= shreg >> 8;
            byte_idx <= byte_idx + 1'b1;
            if (word_done || clear) begin
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/mem_dump.sv
// -----------------------------------------------------------------------------
// mem_dump
// Streams the whole circular sample memory to the UART, starting at the
// trigger address and wrapping, one read per word and BPW bytes per word.
//   clk_50mhz : system clock
//   reset     : async active-low reset
//   bus       : activate/done handshake, start_addr, memory read port,
//               tx byte stream (see mem_dump_if)
//
// state | meaning
// IDLE  | waiting for activate, start_addr latched on entry to READ
// READ  | mem_re pulse at base + word_cnt
// WAIT  | memory returns data, loaded into the serializer at cycle end
// SEND  | bytes of the current word offered to the UART
// DONE  | all words sent, done held until activate drops
// -----------------------------------------------------------------------------
module mem_dump
    import osc_pkg::*;
#(
    parameter int SAMPLE_DEPTH = 8,
    parameter int WIDTH        = 8
) (
    input  logic       clk_50mhz,
    input  logic       reset,
    mem_dump_if.master bus
);
    // word_cnt carries one extra bit so the full-depth count is representable.
    localparam logic [SAMPLE_DEPTH:0] WORDS = {1'b1, {SAMPLE_DEPTH{1'b0}}};

    dump_state_t             state;
    dump_state_t             state_next;
    logic [SAMPLE_DEPTH-1:0] base;
    logic [SAMPLE_DEPTH:0]   word_cnt;
    logic [SAMPLE_DEPTH:0]   word_cnt_inc;
    logic                    start;
    logic                    load;
    logic                    clear;
    logic                    fire;
    logic                    word_done;

    assign word_cnt_inc = word_cnt + 1'b1;
    assign fire         = bus.tx_valid && bus.tx_ready;

    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            base     <= '0;
            word_cnt <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                base     <= bus.start_addr;
                word_cnt <= '0;
            end else if (word_done && state == SEND) begin
                word_cnt <= word_cnt_inc;
            end
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        load       = 1'b0;
        clear      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.activate) begin
                    start      = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
                state_next = bus.activate ? WAIT : IDLE;
            end
            WAIT: begin
                if (!bus.activate) begin
                    state_next = IDLE;
                end else begin
                    load       = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                // An abort still lets the byte on the wire be accepted first.
                if (fire) begin
                    if (!bus.activate) begin
                        clear      = 1'b1;
                        state_next = IDLE;
                    end else if (word_done) begin
                        state_next = (word_cnt_inc == WORDS) ? DONE : READ;
                    end
                end
            end
            DONE: begin
                if (!bus.activate) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Truncating add gives the circular wrap for free.
    assign bus.mem_addr = base + word_cnt[SAMPLE_DEPTH-1:0];
    assign bus.mem_re   = (state == READ);
    assign bus.done     = (state == DONE);

    word_serializer #(
        .WIDTH(WIDTH)
    ) u_ser (
        .clk      (clk_50mhz),
        .rst_n    (reset),
        .load     (load),
        .clear    (clear),
        .word     (bus.mem_data),
        .tx_ready (bus.tx_ready),
        .tx_data  (bus.tx_data),
        .tx_valid (bus.tx_valid),
        .word_done(word_done)
    );
endmodule
